// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, requester indices and write-request type for register-file writeback.
package rf_pkg;
  localparam int RF_ADDR_W = 4;
  localparam int RF_DATA_W = 8;
  typedef enum logic {REQ_ALU = 1'b0, REQ_LD = 1'b1} req_idx_e;
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with one-hot grant; priority passes to the loser after each grant.
module rr_arb2
  import rf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic rr_ptr_q, rr_ptr_d;
  always_comb begin
    gnt = reset ? 2'b00 : (&req) ? (rr_ptr_q ? 2'b10 : 2'b01) : req;
    rr_ptr_d = (|gnt) ? gnt[REQ_ALU] : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= 1'b0;
    else rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates ALU and load writebacks onto one register-file write port with a
// one-stage write buffer, forwards the buffered write onto both read paths and counts contention.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] read0_addr,
  input  logic [ADDR_W-1:0] read1_addr,
  input  logic [DATA_W-1:0] rf_read0_val,
  input  logic [DATA_W-1:0] rf_read1_val,
  output logic [DATA_W-1:0] read0_val_o,
  output logic [DATA_W-1:0] read1_val_o,
  output logic [7:0]        conflict_cnt
);
  logic [1:0]        gnt;
  logic              acc, drop;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] sel_addr, waddr_q, waddr_d;
  logic [DATA_W-1:0] sel_data, wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({ld_valid, alu_valid}),
    .gnt   (gnt)
  );

  always_comb begin
    alu_ready = gnt[REQ_ALU];
    ld_ready = gnt[REQ_LD];
    acc = |gnt;
    sel_addr = gnt[REQ_LD] ? ld_addr : alu_addr;
    sel_data = gnt[REQ_LD] ? ld_data : alu_data;
    drop = (ZERO_REG != 0) && (sel_addr == '0);
    wen_d = acc && !drop;
    waddr_d = acc ? sel_addr : waddr_q;
    wdata_d = acc ? sel_data : wdata_q;
    cnt_d = (alu_valid && ld_valid && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    // A write one cycle old has not landed yet, so the buffer overrides the array read.
    read0_val_o = (wen_q && waddr_q == read0_addr) ? wdata_q : rf_read0_val;
    read1_val_o = (wen_q && waddr_q == read1_addr) ? wdata_q : rf_read1_val;
    rf_wen = wen_q;
    rf_waddr = waddr_q;
    rf_wdata = wdata_q;
    conflict_cnt = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wen_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
    end else begin
      wen_q <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and randomized checks of rf_write_arbiter against a register-file-level model.
module tb_rf_write_arbiter;
  import rf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, alu_valid, ld_valid;
  logic [3:0] alu_addr, ld_addr, read0_addr, read1_addr;
  logic [7:0] alu_data, ld_data, rf_read0_val, rf_read1_val;
  logic       alu_ready, ld_ready, rf_wen;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata, read0_val_o, read1_val_o, conflict_cnt;
  logic       z_alu_ready, z_ld_ready, z_wen;
  logic [3:0] z_waddr;
  logic [7:0] z_wdata, z_rd0, z_rd1, z_cnt;

  rf_write_arbiter #(.ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .read0_addr(read0_addr), .read1_addr(read1_addr),
    .rf_read0_val(rf_read0_val), .rf_read1_val(rf_read1_val),
    .read0_val_o(read0_val_o), .read1_val_o(read1_val_o), .conflict_cnt(conflict_cnt)
  );

  rf_write_arbiter #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(z_alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(z_ld_ready),
    .rf_wen(z_wen), .rf_waddr(z_waddr), .rf_wdata(z_wdata),
    .read0_addr(read0_addr), .read1_addr(read1_addr),
    .rf_read0_val(rf_read0_val), .rf_read1_val(rf_read1_val),
    .read0_val_o(z_rd0), .read1_val_o(z_rd1), .conflict_cnt(z_cnt)
  );

  int passed = 0, total = 0;
  // mem is the physical array (bench plays the register file); arch holds the value software expects.
  logic [7:0] mem[16], arch[16];
  logic       pend_wen, z_pend, alu_pref;
  logic [3:0] pend_a;
  logic [7:0] pend_d;
  int         cnt, last_w;
  logic       last_alu_rdy, last_ld_rdy;
  logic [7:0] last_r0, last_r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int winner(input logic av, input logic lv, input logic pref);
    if (av && (!lv || pref)) return 1;
    if (lv) return 2;
    return 0;
  endfunction

  task automatic step(input logic rst, input logic av, input logic [3:0] aa, input logic [7:0] ad,
                      input logic lv, input logic [3:0] la, input logic [7:0] ldd,
                      input logic [3:0] r0, input logic [3:0] r1);
    int w;
    @(negedge clk);
    reset = rst; alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    read0_addr = r0; read1_addr = r1;
    rf_read0_val = mem[r0]; rf_read1_val = mem[r1];
    #1;
    w = rst ? 0 : winner(av, lv, alu_pref);
    last_w = w;
    chk("alu_ready", alu_ready, w == 1);
    chk("ld_ready", ld_ready, w == 2);
    chk("rf_wen", rf_wen, pend_wen);
    chk("rf_waddr", rf_waddr, pend_a);
    chk("rf_wdata", rf_wdata, pend_d);
    chk("read0", read0_val_o, arch[r0]);
    chk("read1", read1_val_o, arch[r1]);
    chk("conflict_cnt", conflict_cnt, cnt);
    chk("z_wen", z_wen, z_pend);
    chk("z_alu_ready", z_alu_ready, w == 1);
    last_alu_rdy = alu_ready; last_ld_rdy = ld_ready;
    last_r0 = read0_val_o; last_r1 = read1_val_o;
    @(posedge clk);
    if (pend_wen) mem[pend_a] = pend_d;
    if (rst) begin
      pend_wen = 0; z_pend = 0; pend_a = 0; pend_d = 0; alu_pref = 1; cnt = 0;
    end else begin
      if (av && lv && cnt < 255) cnt++;
      pend_wen = (w != 0);
      if (w != 0) begin
        pend_a = (w == 1) ? aa : la;
        pend_d = (w == 1) ? ad : ldd;
        arch[pend_a] = pend_d;
        alu_pref = (w == 2);
      end
      z_pend = pend_wen && pend_a != 0;
    end
  endtask

  initial begin
    logic    g[4];
    logic    a_v, l_v, rst;
    wr_req_t a_r, l_r;
    reset = 1; alu_valid = 0; ld_valid = 0; alu_addr = 0; ld_addr = 0; alu_data = 0; ld_data = 0;
    read0_addr = 0; read1_addr = 0; rf_read0_val = 0; rf_read1_val = 0;
    for (int i = 0; i < 16; i++) begin mem[i] = 8'($urandom); arch[i] = mem[i]; end
    pend_wen = 0; z_pend = 0; pend_a = 0; pend_d = 0; alu_pref = 1; cnt = 0;
    repeat (2) @(posedge clk);
    step(1, 1, 4'h2, 8'h11, 1, 4'h3, 8'h22, 0, 1);
    chk("reset_no_alu_grant", last_alu_rdy, 0);
    chk("reset_no_ld_grant", last_ld_rdy, 0);

    step(0, 1, 4'h3, 8'h5A, 0, 0, 0, 3, 4);
    chk("alu_only_ready", last_alu_rdy, 1);
    chk("alu_only_ld_idle", last_ld_rdy, 0);
    #1;
    chk("alu_only_wen", rf_wen, 1);
    chk("alu_only_waddr", rf_waddr, 4'h3);
    chk("alu_only_wdata", rf_wdata, 8'h5A);
    step(0, 0, 0, 0, 0, 0, 0, 3, 4);
    chk("alu_only_fwd", last_r0, 8'h5A);

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 4'h1, 8'hA1, 1, 4'h2, 8'hB2, 1, 2);
      g[i] = last_alu_rdy;
    end
    chk("cont_g0", g[0], 1);
    chk("cont_g1", g[1], 0);
    chk("cont_g2", g[2], 1);
    chk("cont_g3", g[3], 0);
    #1;
    chk("cont_cnt4", conflict_cnt, 4);

    mem[7] = 8'h00; arch[7] = 8'h00;
    step(0, 0, 0, 0, 1, 4'h7, 8'hC3, 7, 6);
    step(0, 0, 0, 0, 0, 0, 0, 7, 6);
    chk("fwd_read0", last_r0, 8'hC3);
    chk("fwd_read1_raw", last_r1, mem[6]);

    step(0, 1, 4'h0, 8'h77, 0, 0, 0, 0, 5);
    #1;
    chk("zero_reg_wen", z_wen, 0);
    chk("nonzero_reg_wen", rf_wen, 1);

    step(0, 1, 4'h5, 8'h9C, 0, 0, 0, 5, 6);
    step(1, 1, 4'h5, 8'h9C, 1, 4'h6, 8'hD4, 5, 6);
    chk("rst_alu_ready", last_alu_rdy, 0);
    chk("rst_ld_ready", last_ld_rdy, 0);
    #1;
    chk("rst_wen", rf_wen, 0);
    step(0, 1, 4'h5, 8'h9C, 1, 4'h6, 8'hD4, 5, 6);
    chk("rst_ptr_alu_first", last_alu_rdy, 1);

    for (int i = 0; i < 300; i++)
      step(0, 1, 4'h1, 8'hA1, 1, 4'h2, 8'hB2, 4'($urandom), 4'($urandom));
    #1;
    chk("cnt_saturated", conflict_cnt, 255);
    step(0, 1, 4'h1, 8'hA1, 1, 4'h2, 8'hB2, 1, 2);

    a_v = 0; l_v = 0; a_r = '0; l_r = '0;
    for (int i = 0; i < 400; i++) begin
      if (!a_v) begin
        a_v = $urandom_range(0, 2) != 0;
        a_r.addr = 4'($urandom); a_r.data = 8'($urandom);
      end
      if (!l_v) begin
        l_v = $urandom_range(0, 2) != 0;
        l_r.addr = 4'($urandom); l_r.data = 8'($urandom);
      end
      rst = $urandom_range(0, 49) == 0;
      step(rst, a_v, a_r.addr, a_r.data, l_v, l_r.addr, l_r.data, 4'($urandom), 4'($urandom));
      if (last_w == 1) a_v = 0;
      if (last_w == 2) l_v = 0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single synchronous write port of the 16x8 register file between two writeback sources: ALU result (req 0) and memory load return (req 1).
- Round-robin arbitration with a valid/ready handshake per source; the winner is registered into a one-stage write buffer that drives the register-file write port.
- Also forwards the buffered write onto both combinational read paths, so a write one cycle old is visible before it lands in the array.
- Sits between the execute/memory stages and the register file.

Parameters:
- ADDR_W, 4, register address width (2**ADDR_W registers)
- DATA_W, 8, register data width
- ZERO_REG, 0, 1 = register 0 is hard-wired: writes to address 0 are accepted but never reach the port

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU writeback request
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load writeback request
- ld_addr  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- ld_ready  out  1  load request accepted this cycle
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- read0_addr  in  ADDR_W  read pointer rs (also driven to the register file)
- read1_addr  in  ADDR_W  read pointer rt
- rf_read0_val  in  DATA_W  raw register-file read 0
- rf_read1_val  in  DATA_W  raw register-file read 1
- read0_val_o  out  DATA_W  forwarded read 0
- read1_val_o  out  DATA_W  forwarded read 1
- conflict_cnt  out  8  saturating count of cycles with both requests valid

Behaviour:
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, rr_ptr=0 (ALU preferred first), conflict_cnt=0. alu_ready and ld_ready are 0 while reset is high.
- Handshake: transfer occurs when valid && ready. Ready is combinational from both valids and rr_ptr. Ready is asserted only for the granted requester and only when its valid is high.
- The buffer never back-pressures, because the register file accepts a write every cycle.
- A requester must hold addr/data stable while valid is high and not yet ready.
- Grant rules:
  - Only one valid: that requester wins.
  - Both valid: the requester with rr_ptr priority wins (rr_ptr=0 -> ALU, rr_ptr=1 -> load).
  - After any grant, rr_ptr <= index of the loser, i.e. the other requester.
  - Neither valid: no grant, rr_ptr holds.
- Latency: an accepted request appears on rf_wen/rf_waddr/rf_wdata exactly 1 cycle later and is written into the array at the following edge.
- Buffer update: when no request is accepted, rf_wen <= 0; rf_waddr and rf_wdata hold their previous values.
- ZERO_REG=1 with an accepted address of 0: ready is still asserted, but rf_wen <= 0.
- Forwarding: readN_val_o = (rf_wen && rf_waddr == readN_addr) ? rf_wdata : rf_readN_val, evaluated independently for each read port.
- conflict_cnt increments on every cycle with alu_valid && ld_valid (reset low). It saturates at 255.
- Back-to-back transfers: a requester holding valid high for consecutive cycles while the other is idle is accepted every cycle.
- Under sustained contention, grants strictly alternate.
- Reset mid-operation: a buffered write is discarded (rf_wen=0 on the cycle after reset is sampled). rr_ptr returns to 0. Requests presented during reset are not accepted.
- Same-address writes from both sources in a contention cycle: serialized by arbitration order; the later grant wins in the array.

Decomposition:
- Package rf_pkg holds:
  - RF_ADDR_W=4 and RF_DATA_W=8 defaults
  - a requester-index enum (REQ_ALU=0, REQ_LD=1)
  - a packed write-request struct {addr, data}
- Sub-module rr_arb2: a 2-input round-robin arbiter with valid inputs, a one-hot grant output and an internal rr_ptr register with synchronous reset. It is reused later for memory-port sharing.
- Top level contains the request mux, the write buffer, the forwarding muxes and conflict_cnt.

Test Plan:
- Reset, then ALU only (alu_valid=1, addr=3, data=8'h5A) -> alu_ready=1 the same cycle; next cycle rf_wen=1, rf_waddr=3, rf_wdata=8'h5A; ld_ready=0 throughout.
- Both valid for 4 cycles after reset (ALU addr 1, load addr 2) -> grants ALU, load, ALU, load; conflict_cnt=4.
- Forwarding: accept load addr=7, data=8'hC3 while rf_read0_val=8'h00 and read0_addr=7 -> on the cycle rf_wen=1, read0_val_o=8'hC3. With read1_addr=6, read1_val_o=rf_read1_val.
- ZERO_REG=1, ALU write addr=0 -> alu_ready=1, next cycle rf_wen=0. The same with ZERO_REG=0 gives rf_wen=1.
- Reset asserted the cycle after an accepted write -> rf_wen=0 on the next cycle, rr_ptr=0, and alu_ready=ld_ready=0 while reset is high.
- 300 cycles of continuous contention -> conflict_cnt saturates at 255 and stays there; grants keep alternating.
